// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-cycle shift-add multiply
// and restoring divide, with MTHI/MTLO write ports.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz_out;

  logic             w_is_div;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  // Operand decode: op[0] selects unsigned, op[1] selects divide
  assign w_is_div = op[1];
  assign w_a_neg  = !op[0] && src_a[WIDTH-1];
  assign w_b_neg  = !op[0] && src_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -src_a : src_a;
  assign w_b_mag  = w_b_neg ? -src_b : src_b;
  assign w_b_zero = (src_b == '0);
  assign w_accept = start && (r_state != S_RUN);

  // One iteration step for each algorithm
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_b & {WIDTH{r_q[0]}}};
  assign w_shift = {r_acc, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[WIDTH-1:0] - r_b;

  // Sign fix-up applied only when the result is written
  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quot     = r_neg_res ? -r_q : r_q;
  assign w_rem      = r_neg_rem ? -r_acc : r_acc;
  assign w_res_hi   = r_is_div ? w_rem  : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_res_lo   = r_is_div ? w_quot : w_prod_fix[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FINISH also accepts a new start so back-to-back ops lose no cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_FINISH: begin
        w_next = S_IDLE;
        if (start) w_next = (w_is_div && w_b_zero) ? S_FINISH : S_RUN;
      end
      S_RUN:    if (r_cnt == CW'(WIDTH - 1)) w_next = S_FINISH;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= w_is_div ? w_a_mag : w_b_mag;
      r_b       <= w_is_div ? w_b_mag : w_a_mag;
      r_is_div  <= w_is_div;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_dbz     <= w_is_div && w_b_zero;
    end else if (r_state == S_RUN) begin
      r_cnt <= CW'(r_cnt + 1'b1);
      if (r_is_div) begin
        r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], w_ge};
      end else begin
        r_acc <= w_sum[WIDTH:1];
        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
      end
    end
  end

  // Architectural registers: a completing result takes priority over MTHI/MTLO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
    end else begin
      r_busy    <= (w_next == S_RUN);
      r_done    <= (r_state == S_FINISH);
      r_dbz_out <= (r_state == S_FINISH) && r_dbz;
      if (hi_we && !r_busy) r_hi <= src_a;
      if (lo_we && !r_busy) r_lo <= src_a;
      if (r_state == S_FINISH && !r_dbz) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz_out;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// traffic checked every cycle against a countdown-based arithmetic model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int errors;
  int checks;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: m_cnt counts edges until the pending result lands
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done, m_dbz, p_dbz;
  int          m_cnt;

  initial begin
    errors = 0; checks = 0;
    m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
    m_done = 1'b0; m_dbz = 1'b0; p_dbz = 1'b0; m_cnt = 0;
  end

  function automatic logic [63:0] model_res(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: res = 64'(sa * sb);
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      default: res = {a % b, a / b};
    endcase
    return res;
  endfunction

  always @(posedge clk) begin : model
    bit prev_busy;
    logic [63:0] r;
    prev_busy = (m_cnt >= 2);
    if (reset) begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (hi_we && !prev_busy) m_hi = src_a;
      if (lo_we && !prev_busy) m_lo = src_a;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_dbz  = p_dbz;
          if (!p_dbz) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end
      if (start && !prev_busy) begin
        if (op[1] && src_b == 32'd0) begin
          p_dbz = 1'b1;
          m_cnt = 1;
        end else begin
          p_dbz = 1'b0;
          r = model_res(op, src_a, src_b);
          p_hi = r[63:32];
          p_lo = r[31:0];
          m_cnt = 33;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_hi",   hi,                m_hi);
    chk("cyc_lo",   lo,                m_lo);
    chk("cyc_busy", 32'(busy),         32'(m_cnt >= 2));
    chk("cyc_done", 32'(done),         32'(m_done));
    chk("cyc_dbz",  32'(div_by_zero),  32'(m_dbz));
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns edges from acceptance to done; 40 marks a timeout
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles = busy_cycles + 1;
      @(negedge clk);
      lat = lat + 1;
    end
  endtask

  task automatic count_done(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen = seen + 1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin : stim
    int lat, bc, seen;
    reset = 1'b1; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy_done_dbz", {29'd0, busy, done, div_by_zero}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // MULTU all-ones squared
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    chk("multu_latency", 32'(lat), 32'd33);
    chk("multu_busy_cycles", 32'(bc), 32'd32);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    chk("model_multu_hi", m_hi, 32'hFFFF_FFFE);

    // MULT -3 x 5
    issue(2'd0, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done(lat, bc);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    chk("model_mult_lo", m_lo, 32'hFFFF_FFF1);

    // DIV -7 / 2
    issue(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(lat, bc);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_no_dbz", 32'(div_by_zero), 32'd0);

    // MTLO preload then DIVU by zero
    lo_we = 1'b1; src_a = 32'h1234_5678;
    @(negedge clk);
    lo_we = 1'b0;
    issue(2'd3, 32'd100, 32'd0);
    wait_done(lat, bc);
    chk("dbz_latency", 32'(lat), 32'd1);
    chk("dbz_flag", 32'(div_by_zero), 32'd1);
    chk("dbz_lo_kept", lo, 32'h1234_5678);
    chk("model_dbz_lo", m_lo, 32'h1234_5678);

    // Overflowing DIV with a second start mid-run
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    issue(2'd1, 32'd3, 32'd3);
    wait_done(lat, bc);
    chk("ovf_latency", 32'(lat), 32'd28);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);
    chk("ovf_no_dbz", 32'(div_by_zero), 32'd0);
    count_done(40, seen);
    chk("ignored_start_no_done", 32'(seen), 32'd0);

    // Reset during the 10th RUN cycle of MULTU 7x6
    hi_we = 1'b1; lo_we = 1'b1; src_a = 32'h1111_1111;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("preload_hi", hi, 32'h1111_1111);
    issue(2'd1, 32'd7, 32'd6);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    count_done(40, seen);
    chk("abort_no_done", 32'(seen), 32'd0);
    issue(2'd1, 32'd7, 32'd6);
    wait_done(lat, bc);
    chk("restart_lo", lo, 32'h0000_002A);
    chk("restart_hi", hi, 32'h0);

    // Random traffic, checked every cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 4 == 0);
      op    = 2'($urandom);
      src_a = pick();
      src_b = pick();
      hi_we = ($urandom % 8 == 0);
      lo_we = ($urandom % 8 == 0);
      reset = ($urandom % 400 == 0);
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, the operand width; only 32 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request to begin the operation selected by op.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port src_a, input, 32 bits: register file ReadData1, the multiplicand or dividend.
REQ-007 The block SHALL have port src_b, input, 32 bits: register file ReadData2, the multiplier or divisor.
REQ-008 The block SHALL have ports hi_we and lo_we, input, 1 bit each: MTHI and MTLO write enables, taking data from src_a.
REQ-009 The block SHALL have ports hi and lo, output, 32 bits each: the architectural HI and LO registers.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse in the cycle hi and lo take a result.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: pulses with done when a DIV or DIVU had src_b equal to 0.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FINISH.
REQ-014 In IDLE, start=1 SHALL capture op, src_a and src_b and move to RUN; busy rises in the next cycle.
REQ-015 While busy=1, start SHALL be ignored and the captured operands SHALL NOT change.
REQ-016 RUN SHALL execute exactly 32 iteration cycles, one bit per cycle, then move to FINISH.
REQ-017 FINISH SHALL write hi and lo, pulse done for one cycle, clear busy, and return to IDLE.
REQ-018 If start is accepted on edge N, hi, lo and done SHALL become valid on edge N+33, and a new start SHALL be accepted on that edge.
REQ-019 MULTU SHALL compute a shift-add 64-bit product, with hi taking bits 63:32 and lo taking bits 31:0.
REQ-020 MULT SHALL multiply the operand magnitudes and negate the 64-bit result (two's complement) when the operand signs differ.
REQ-021 DIVU SHALL use restoring division, with lo taking the quotient and hi taking the remainder.
REQ-022 DIV SHALL divide the magnitudes, negate the quotient when the signs differ, and give the remainder the dividend's sign.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL wrap to lo=0x80000000 and hi=0x00000000 without any flag.
REQ-024 A divide with src_b=0 SHALL skip RUN, pulse done and div_by_zero on edge N+1, and leave hi and lo unchanged.
REQ-025 hi_we or lo_we SHALL update the corresponding register on the next edge only when busy=0; both enables may be active in one cycle.
REQ-026 hi_we or lo_we asserted while busy=1 SHALL be ignored.
REQ-027 hi_we or lo_we asserted in the same cycle as an accepted start SHALL be applied, and the later result SHALL then overwrite it at done.
REQ-028 hi and lo SHALL hold their values between results, and intermediate accumulator values SHALL never appear on hi or lo.
REQ-029 A multiply SHALL never assert div_by_zero.

Reset
REQ-030 When reset=1 on an edge, the block SHALL set state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0 and clear all internal accumulators and counters.
REQ-031 Reset SHALL override start, hi_we and lo_we in the same cycle.
REQ-032 Reset during RUN SHALL abort the operation with no done pulse; the block SHALL accept a new start on the first edge after reset is released.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF SHALL give busy=1 for 32 cycles, then done with hi=0xFFFFFFFE and lo=0x00000001 on edge N+33.
REQ-034 MULT 0xFFFFFFFD (-3) x 0x00000005 SHALL give hi=0xFFFFFFFF and lo=0xFFFFFFF1.
REQ-035 DIV 0xFFFFFFF9 (-7) / 0x00000002 SHALL give lo=0xFFFFFFFD and hi=0xFFFFFFFF.
REQ-036 With lo_we and src_a=0x12345678 preloaded, DIVU 100/0 SHALL give done=div_by_zero=1 on edge N+1 with lo still 0x12345678.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, and a second start during that run SHALL be ignored.
REQ-038 With hi=lo=0x11111111, reset asserted on the 10th RUN cycle of MULTU 7x6 SHALL give hi=lo=0, busy=0 and no done; a restart SHALL then give lo=0x0000002A.
